// File: rtl/tdm_demux2.sv
// Two-channel TDM demultiplexer: locks onto the channel-0 sync marker, pairs each
// channel-0 sample with the following channel-1 sample and presents both at once.
module tdm_demux2 #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] d_i,
    input  logic         dv_i,
    input  logic         sync_i,
    input  logic         clr_err_i,
    output logic [W-1:0] y0_o,
    output logic [W-1:0] y1_o,
    output logic         yv_o,
    output logic         s0_o,
    output logic         locked_o,
    output logic         err_o,
    output logic [7:0]   frame_cnt_o
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        CH0  = 2'd1,
        CH1  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] h_q, h_d;
    logic [W-1:0] y0_q, y0_d;
    logic [W-1:0] y1_q, y1_d;
    logic         yv_q, yv_d;
    logic         err_q, err_d;
    logic [7:0]   cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (dv_i) begin
            case (state_q)
                HUNT:    if (sync_i) state_d = CH1;
                CH0:     state_d = CH1;
                CH1:     if (!sync_i) state_d = CH0;
                default: state_d = HUNT;
            endcase
        end
    end

    // A sync seen while waiting for channel 1 restarts the frame on the new sample.
    always_comb begin
        h_d   = h_q;
        y0_d  = y0_q;
        y1_d  = y1_q;
        yv_d  = 1'b0;
        err_d = err_q;
        cnt_d = cnt_q;
        if (clr_err_i) begin
            err_d = 1'b0;
        end
        if (dv_i) begin
            case (state_q)
                HUNT: begin
                    if (sync_i) h_d = d_i;
                end
                CH0: begin
                    h_d = d_i;
                end
                CH1: begin
                    if (sync_i) begin
                        err_d = 1'b1;
                        h_d   = d_i;
                    end else begin
                        y0_d  = h_q;
                        y1_d  = d_i;
                        yv_d  = 1'b1;
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h_q   <= '0;
            y0_q  <= '0;
            y1_q  <= '0;
            yv_q  <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            h_q   <= h_d;
            y0_q  <= y0_d;
            y1_q  <= y1_d;
            yv_q  <= yv_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        s0_o        = (state_q == CH1);
        locked_o    = (state_q != HUNT);
        y0_o        = y0_q;
        y1_o        = y1_q;
        yv_o        = yv_q;
        err_o       = err_q;
        frame_cnt_o = cnt_q;
    end

endmodule

// File: tb/tb_tdm_demux2.sv
// Directed self-checking bench for tdm_demux2: one task per scenario, inline checks.
module tb_tdm_demux2;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [7:0] d_i;
    logic       dv_i;
    logic       sync_i;
    logic       clr_err_i;
    logic [7:0] y0_o;
    logic [7:0] y1_o;
    logic       yv_o;
    logic       s0_o;
    logic       locked_o;
    logic       err_o;
    logic [7:0] frame_cnt_o;

    int tests = 0;
    int fails = 0;

    tdm_demux2 #(.W(8)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .d_i         (d_i),
        .dv_i        (dv_i),
        .sync_i      (sync_i),
        .clr_err_i   (clr_err_i),
        .y0_o        (y0_o),
        .y1_o        (y1_o),
        .yv_o        (yv_o),
        .s0_o        (s0_o),
        .locked_o    (locked_o),
        .err_o       (err_o),
        .frame_cnt_o (frame_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n_i   = 1'b0;
        dv_i      = 1'b0;
        sync_i    = 1'b0;
        d_i       = 8'h00;
        clr_err_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input logic s);
        d_i    = d;
        sync_i = s;
        dv_i   = 1'b1;
        @(posedge clk_i);
        #1;
        dv_i   = 1'b0;
        sync_i = 1'b0;
        $display("[TB] t=%0t sample d=%02h sync=%0b -> y0=%02h y1=%02h yv=%0b s0=%0b lk=%0b err=%0b cnt=%0d",
                 $time, d, s, y0_o, y1_o, yv_o, s0_o, locked_o, err_o, frame_cnt_o);
    endtask

    task automatic idle(input int n);
        dv_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        dv_i = 1'b0; sync_i = 1'b0; d_i = 8'h00; clr_err_i = 1'b0;
        #1;
        tests++; if ({y0_o, y1_o} !== 16'h0000) begin fails++; $display("FAIL reset_y: actual=%04h required=0000", {y0_o, y1_o}); end
        tests++; if ({yv_o, s0_o, locked_o, err_o} !== 4'b0000) begin fails++; $display("FAIL reset_flags: actual=%04b required=0000", {yv_o, s0_o, locked_o, err_o}); end
        tests++; if (frame_cnt_o !== 8'd0) begin fails++; $display("FAIL reset_cnt: actual=%0d required=0", frame_cnt_o); end
        do_reset();
    endtask

    task automatic test_lock_pair();
        do_reset();
        tests++; if (s0_o !== 1'b0) begin fails++; $display("FAIL lock_s0_initial: actual=%0b required=0", s0_o); end
        send(8'h11, 1'b1);
        tests++; if ({s0_o, locked_o, yv_o} !== 3'b110) begin fails++; $display("FAIL lock_after_ch0: actual=%03b required=110", {s0_o, locked_o, yv_o}); end
        send(8'h22, 1'b0);
        tests++; if (yv_o !== 1'b1) begin fails++; $display("FAIL lock_yv: actual=%0b required=1", yv_o); end
        tests++; if ({y0_o, y1_o} !== 16'h1122) begin fails++; $display("FAIL lock_pair: actual=%04h required=1122", {y0_o, y1_o}); end
        tests++; if (frame_cnt_o !== 8'd1) begin fails++; $display("FAIL lock_cnt: actual=%0d required=1", frame_cnt_o); end
        tests++; if ({s0_o, locked_o} !== 2'b01) begin fails++; $display("FAIL lock_s0_locked: actual=%02b required=01", {s0_o, locked_o}); end
        idle(1);
        tests++; if (yv_o !== 1'b0) begin fails++; $display("FAIL lock_yv_one_cycle: actual=%0b required=0", yv_o); end
        tests++; if ({y0_o, y1_o} !== 16'h1122) begin fails++; $display("FAIL lock_hold: actual=%04h required=1122", {y0_o, y1_o}); end
    endtask

    task automatic test_hunt_discard();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(8'hAA, 1'b0);
            tests++; if ({locked_o, yv_o, err_o, s0_o} !== 4'b0000) begin fails++; $display("FAIL hunt_flags[%0d]: actual=%04b required=0000", i, {locked_o, yv_o, err_o, s0_o}); end
            tests++; if ({y0_o, y1_o} !== 16'h0000) begin fails++; $display("FAIL hunt_y[%0d]: actual=%04h required=0000", i, {y0_o, y1_o}); end
        end
    endtask

    task automatic test_misalign();
        do_reset();
        send(8'h01, 1'b1);
        tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL mis_err_early: actual=%0b required=0", err_o); end
        send(8'h02, 1'b1);
        tests++; if ({err_o, yv_o, s0_o} !== 3'b101) begin fails++; $display("FAIL mis_err_set: actual=%03b required=101", {err_o, yv_o, s0_o}); end
        tests++; if (frame_cnt_o !== 8'd0) begin fails++; $display("FAIL mis_cnt_hold: actual=%0d required=0", frame_cnt_o); end
        send(8'h03, 1'b0);
        tests++; if ({y0_o, y1_o} !== 16'h0203) begin fails++; $display("FAIL mis_resync_pair: actual=%04h required=0203", {y0_o, y1_o}); end
        tests++; if ({yv_o, frame_cnt_o} !== {1'b1, 8'd1}) begin fails++; $display("FAIL mis_yv_cnt: actual=%0b/%0d required=1/1", yv_o, frame_cnt_o); end
        tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL mis_err_sticky: actual=%0b required=1", err_o); end
        clr_err_i = 1'b1;
        idle(1);
        clr_err_i = 1'b0;
        tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL mis_clr: actual=%0b required=0", err_o); end
        send(8'h04, 1'b1);
        clr_err_i = 1'b1;
        send(8'h05, 1'b1);
        clr_err_i = 1'b0;
        tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL mis_set_wins: actual=%0b required=1", err_o); end
        tests++; if (frame_cnt_o !== 8'd1) begin fails++; $display("FAIL mis_cnt_after: actual=%0d required=1", frame_cnt_o); end
    endtask

    task automatic test_gaps();
        do_reset();
        send(8'hA1, 1'b1);
        send(8'hA2, 1'b0);
        send(8'h10, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            tests++; if ({y0_o, y1_o} !== 16'hA1A2) begin fails++; $display("FAIL gap_hold[%0d]: actual=%04h required=a1a2", i, {y0_o, y1_o}); end
            tests++; if ({yv_o, s0_o} !== 2'b01) begin fails++; $display("FAIL gap_flags[%0d]: actual=%02b required=01", i, {yv_o, s0_o}); end
        end
        send(8'h20, 1'b0);
        tests++; if ({y0_o, y1_o, yv_o} !== {16'h1020, 1'b1}) begin fails++; $display("FAIL gap_pair: actual=%04h/%0b required=1020/1", {y0_o, y1_o}, yv_o); end
        idle(1);
        tests++; if (yv_o !== 1'b0) begin fails++; $display("FAIL gap_single_yv: actual=%0b required=0", yv_o); end
        tests++; if (frame_cnt_o !== 8'd2) begin fails++; $display("FAIL gap_cnt: actual=%0d required=2", frame_cnt_o); end
    endtask

    task automatic test_back_to_back_wrap();
        logic [7:0] a;
        logic [7:0] exp_cnt;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            a = i[7:0];
            exp_cnt = a + 8'd1;
            send(a, 1'b1);
            tests++; if (yv_o !== 1'b0) begin fails++; $display("FAIL b2b_yv_low[%0d]: actual=%0b required=0", i, yv_o); end
            send(~a, 1'b0);
            tests++; if ({yv_o, y0_o, y1_o} !== {1'b1, a, ~a}) begin fails++; $display("FAIL b2b_frame[%0d]: actual=%0b/%02h/%02h required=1/%02h/%02h", i, yv_o, y0_o, y1_o, a, ~a); end
            tests++; if (frame_cnt_o !== exp_cnt) begin fails++; $display("FAIL b2b_cnt[%0d]: actual=%0d required=%0d", i, frame_cnt_o, exp_cnt); end
        end
        tests++; if ({frame_cnt_o, err_o} !== {8'd0, 1'b0}) begin fails++; $display("FAIL wrap_final: actual=%0d/%0b required=0/0", frame_cnt_o, err_o); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        send(8'h77, 1'b1);
        send(8'h78, 1'b0);
        send(8'h55, 1'b1);
        #2;
        rst_n_i = 1'b0;
        #1;
        tests++; if ({y0_o, y1_o} !== 16'h0000) begin fails++; $display("FAIL midrst_y: actual=%04h required=0000", {y0_o, y1_o}); end
        tests++; if ({yv_o, s0_o, locked_o, err_o, frame_cnt_o} !== 12'h000) begin fails++; $display("FAIL midrst_flags: actual=%0b%0b%0b%0b/%0d required=0000/0", yv_o, s0_o, locked_o, err_o, frame_cnt_o); end
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        send(8'h66, 1'b0);
        tests++; if ({locked_o, yv_o} !== 2'b00) begin fails++; $display("FAIL midrst_discard: actual=%02b required=00", {locked_o, yv_o}); end
        send(8'h99, 1'b1);
        send(8'hAB, 1'b0);
        tests++; if ({y0_o, y1_o} !== 16'h99AB) begin fails++; $display("FAIL midrst_no_stale: actual=%04h required=99ab", {y0_o, y1_o}); end
        tests++; if (frame_cnt_o !== 8'd1) begin fails++; $display("FAIL midrst_cnt: actual=%0d required=1", frame_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_lock_pair();
        test_hunt_discard();
        test_misalign();
        test_gaps();
        test_back_to_back_wrap();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tdm_demux2.md
# tdm_demux2

Two-channel time-division demultiplexer: the receive end of the 2:1 select path. An upstream 2:1 mux alternates channel 0 and channel 1 samples onto one shared data line. This block recovers the channel pairing from a sync marker, steers each sample to its channel register and presents both channels together with a one-cycle valid pulse. It sits between the shared line and per-channel consumers, and tracks alignment errors and completed frames.

## Interface
- W, 8, data width of shared line and each channel output

- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- D  in  W  shared-line sample
- Dv  in  1  D valid this cycle
- Sync  in  1  qualifies D as a channel-0 sample (frame start); ignored when Dv=0
- ClrErr  in  1  synchronous clear of Err
- Y0  out  W  last complete frame, channel 0
- Y1  out  W  last complete frame, channel 1
- Yv  out  1  one-cycle pulse: Y0/Y1 just updated
- S0  out  1  expected channel of next sample (0 or 1); mirrors upstream select
- Locked  out  1  high when not in HUNT
- Err  out  1  sticky alignment error
- FrameCnt  out  8  completed frames, modulo 256

## Operation
- Three states: HUNT, CH0, CH1. Internal hold register H (W bits) stores the pending channel-0 sample.
- HUNT:
  - Dv=1, Sync=1: H<=D, go to CH1.
  - Dv=1, Sync=0: sample dropped, stay in HUNT, no error.
- CH0:
  - Dv=1 (Sync 0 or 1): H<=D, go to CH1.
- CH1:
  - Dv=1, Sync=0: Y0<=H, Y1<=D, Yv=1, FrameCnt+=1, go to CH0.
  - Dv=1, Sync=1: misaligned. Err<=1, H<=D (resync on new frame start), stay in CH1, no Yv, FrameCnt unchanged.
- Dv=0: no state, H, Y or counter change in any state.
- Y0 and Y1 always update in the same cycle. They never show a mixed frame.
- S0=1 in CH1, 0 in HUNT and CH0. Locked=1 in CH0 and CH1.
- FrameCnt wraps 255->0 with no flag.
- Err is set only by the CH1 misalignment case. It is cleared only by ClrErr or reset.
- Err set and ClrErr in the same cycle: set wins, Err=1.
- The block never returns to HUNT except through reset.

## Timing
- All state and outputs are registered. Nothing is combinational from D, Dv or Sync to the outputs.
- Yv rises the cycle after the Clk edge that samples the channel-1 sample and lasts exactly one cycle. Y0/Y1 take their new values on that same edge and hold until the next completed frame.
- Back-to-back Dv every cycle: one Yv per two samples, sustained throughput of 1 frame per 2 cycles.
- Gaps (Dv=0) between or within a frame are allowed. Pairing is preserved across gaps.
- ClrErr takes effect at the next edge: Err=0 in the following cycle.
- Reset (Rst_n=0, asynchronous, any time including mid-frame): state=HUNT, H=0, Y0=0, Y1=0, Yv=0, S0=0, Locked=0, Err=0, FrameCnt=0. A half-captured frame is discarded.
- After Rst_n rises, the first edge is a normal HUNT cycle.

## Test plan
- Lock and pair (W=8): reset. Then Dv=1 each cycle with (D=0x11, Sync=1), (0x22, 0) -> one cycle later Y0=0x11, Y1=0x22, Yv=1 for exactly one cycle, FrameCnt=1, Locked=1, S0 sequence 0,1,0.
- Hunt discard: after reset, drive D=0xAA, Sync=0, Dv=1 for 3 cycles -> stays in HUNT, Locked=0, Yv never pulses, Y0=Y1=0, Err=0.
- Misalignment: lock with (0x01, Sync=1), then (0x02, Sync=1), then (0x03, Sync=0) -> Err=1 after the second sample, no Yv on it, then Y0=0x02, Y1=0x03, Yv=1, FrameCnt=1. ClrErr=1 for one cycle -> Err=0. Err set and ClrErr together -> Err=1.
- Gaps: (0x10, Sync=1), Dv=0 for 4 cycles, (0x20, 0) -> Y0=0x10, Y1=0x20, single Yv. Y0/Y1 unchanged during the gap.
- Counter wrap: stream 256 aligned frames back-to-back -> Yv every second cycle, FrameCnt reads 0 after frame 256, no error.
- Reset mid-frame: lock, send a channel-0 sample (0x55), assert Rst_n=0 between clock edges -> all outputs drop to reset values immediately (asynchronously). After release, (0x66, Sync=0) is discarded in HUNT and 0x55 never appears on Y0.
